// File: rtl/screen_compositor.sv
// screen_compositor: picks the highest-priority layer colour for each pixel,
// optionally scales it by a fade level, blanks it outside the visible area and
// delays colour and syncs by LAT cycles so that they stay aligned.
// Define SCREEN_COMPOSITOR_FADE_EN to build the fade FSM and colour scaling.
// Without that macro the colour passes through unscaled and fade_busy is 0.
module screen_compositor #(
    parameter int COLOR_BITS  = 4,
    parameter int N_LAYERS    = 4,
    parameter int LAT         = 2,
    parameter int FADE_FRAMES = 4
) (
    input  logic                               clk_25,
    input  logic                               reset,
    input  logic                               hsync_in,
    input  logic                               vsync_in,
    input  logic                               en_in,
    input  logic [N_LAYERS-1:0]                layer_dr,
    input  logic [N_LAYERS*3*COLOR_BITS-1:0]   layer_rgb,
    input  logic [3*COLOR_BITS-1:0]            bg_rgb,
    input  logic                               fade_start,
    input  logic                               fade_dir,
    output logic                               h_sync,
    output logic                               v_sync,
    output logic [COLOR_BITS-1:0]              red,
    output logic [COLOR_BITS-1:0]              green,
    output logic [COLOR_BITS-1:0]              blue,
    output logic                               fade_busy,
    output logic [15:0]                        frame_cnt
);

    localparam int CW = 3 * COLOR_BITS;

    logic                vsync_q;
    logic                frame_boundary;
    logic [CW-1:0]       sel_rgb;
    logic [CW-1:0]       pix_rgb;
    logic [CW-1:0]       rgb_pipe [LAT];
    logic [LAT-1:0]      hs_pipe;
    logic [LAT-1:0]      vs_pipe;

    // A frame ends where vsync_in falls relative to its registered copy.
    assign frame_boundary = vsync_q & ~vsync_in;

    // Registered vsync copy and the completed-frame counter (wraps naturally).
    always_ff @(posedge clk_25) begin
        if (reset) begin
            vsync_q   <= 1'b1;
            frame_cnt <= 16'd0;
        end else begin
            vsync_q   <= vsync_in;
            frame_cnt <= frame_cnt + {15'd0, frame_boundary};
        end
    end

    // Lowest-indexed requesting layer wins; background when nobody requests.
    always_comb begin
        sel_rgb = bg_rgb;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_dr[i]) begin
                sel_rgb = layer_rgb[i*CW +: CW];
            end
        end
    end

`ifdef SCREEN_COMPOSITOR_FADE_EN

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_t;

    localparam int                PW        = 2 * COLOR_BITS;
    localparam logic [COLOR_BITS:0] FULL     = {1'b1, {COLOR_BITS{1'b0}}};
    localparam logic [COLOR_BITS:0] LVL_ZERO = '0;
    localparam logic [COLOR_BITS:0] LVL_ONE  = 1;
    localparam logic [COLOR_BITS:0] NEAR_FULL = FULL - LVL_ONE;
    localparam logic [7:0]        STEP_LAST = 8'(FADE_FRAMES - 1);

    fade_state_t         state;
    logic [COLOR_BITS:0] level;
    logic [7:0]          step_cnt;

    // Full-width product before the shift, so level=2^COLOR_BITS returns c exactly.
    function automatic logic [COLOR_BITS-1:0] scale(input logic [COLOR_BITS-1:0] c,
                                                    input logic [COLOR_BITS:0]   lvl);
        scale = COLOR_BITS'((PW'(c) * PW'(lvl)) >> COLOR_BITS);
    endfunction

    // Fade FSM: a level step every FADE_FRAMES boundaries, ending on the step that hits the limit.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            state     <= IDLE;
            level     <= FULL;
            step_cnt  <= 8'd0;
            fade_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fade_start) begin
                        state     <= fade_dir ? FADE_IN : FADE_OUT;
                        step_cnt  <= 8'd0;
                        fade_busy <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (frame_boundary) begin
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= 8'd0;
                            if (level != LVL_ZERO) begin
                                level <= level - LVL_ONE;
                            end
                            if (level <= LVL_ONE) begin
                                state     <= IDLE;
                                fade_busy <= 1'b0;
                            end
                        end else begin
                            step_cnt <= step_cnt + 8'd1;
                        end
                    end
                end
                FADE_IN: begin
                    if (frame_boundary) begin
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= 8'd0;
                            if (level != FULL) begin
                                level <= level + LVL_ONE;
                            end
                            if (level >= NEAR_FULL) begin
                                state     <= IDLE;
                                fade_busy <= 1'b0;
                            end
                        end else begin
                            step_cnt <= step_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    fade_busy <= 1'b0;
                end
            endcase
        end
    end

    // Scale each channel by the current level, forcing black outside the visible area.
    always_comb begin
        pix_rgb = '0;
        if (en_in) begin
            pix_rgb = {scale(sel_rgb[CW-1 -: COLOR_BITS], level),
                       scale(sel_rgb[2*COLOR_BITS-1 -: COLOR_BITS], level),
                       scale(sel_rgb[COLOR_BITS-1:0], level)};
        end
    end

`else

    localparam int unused_fade_frames = FADE_FRAMES;
    logic unused_fade_inputs;

    assign unused_fade_inputs = ^{fade_start, fade_dir};
    assign fade_busy          = 1'b0;

    // Unscaled colour, forced black outside the visible area.
    always_comb begin
        pix_rgb = '0;
        if (en_in) begin
            pix_rgb = sel_rgb;
        end
    end

`endif

    // LAT-deep colour and sync pipelines; syncs idle high, colour idles black.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                rgb_pipe[i] <= '0;
            end
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            rgb_pipe[0] <= pix_rgb;
            hs_pipe[0]  <= hsync_in;
            vs_pipe[0]  <= vsync_in;
            for (int i = 1; i < LAT; i++) begin
                rgb_pipe[i] <= rgb_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
            end
        end
    end

    assign h_sync = hs_pipe[LAT-1];
    assign v_sync = vs_pipe[LAT-1];
    assign red    = rgb_pipe[LAT-1][CW-1 -: COLOR_BITS];
    assign green  = rgb_pipe[LAT-1][2*COLOR_BITS-1 -: COLOR_BITS];
    assign blue   = rgb_pipe[LAT-1][COLOR_BITS-1:0];

endmodule
